// File: rtl/warp_dispatch_if.sv
`default_nettype none
// ============================================================================
// warp_dispatch_if : per-warp control/status bundle between dispatcher and core
// Revision: 1.0
// ============================================================================
interface warp_dispatch_if #(
  parameter int THREADS_PER_BLOCK = 4
);
  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

  logic           reset_1;
  logic           reset_2;
  logic           start_1;
  logic           start_2;
  logic [7:0]     block_id_1;
  logic [7:0]     block_id_2;
  logic [TCW-1:0] thread_count_1;
  logic [TCW-1:0] thread_count_2;
  logic           done_1;
  logic           done_2;

  modport master (
    output reset_1, reset_2, start_1, start_2,
    output block_id_1, block_id_2, thread_count_1, thread_count_2,
    input  done_1, done_2
  );

  modport slave (
    input  reset_1, reset_2, start_1, start_2,
    input  block_id_1, block_id_2, thread_count_1, thread_count_2,
    output done_1, done_2
  );
endinterface
`default_nettype wire

// File: rtl/warp_dispatch.sv
`default_nettype none
// ============================================================================
// warp_dispatch : splits a kernel into blocks and feeds them to two warp slots
// Revision: 1.0
// ============================================================================
module warp_dispatch #(
  parameter int THREADS_PER_BLOCK = 4
) (
  input  wire        clk,
  input  wire        reset,
  input  wire        start,
  input  wire  [7:0] thread_count,
  output logic       done,
  warp_dispatch_if.master warp
);
  localparam int LOG2 = $clog2(THREADS_PER_BLOCK);
  localparam int TCW  = LOG2 + 1;

  localparam logic [1:0] K_IDLE   = 2'd0;
  localparam logic [1:0] K_RUN    = 2'd1;
  localparam logic [1:0] K_DONE   = 2'd2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RESET  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_RETIRE = 2'd3;

  logic [1:0]     r_rst_sync;
  logic           r_rst_n;
  logic [1:0]     r_kstate;
  logic [1:0]     r_s1;
  logic [1:0]     r_s2;
  logic [7:0]     r_total;
  logic [7:0]     r_next;
  logic [7:0]     r_done_cnt;
  logic [TCW-1:0] r_last_tc;
  logic [7:0]     r_bid1;
  logic [7:0]     r_bid2;
  logic [TCW-1:0] r_tc1;
  logic [TCW-1:0] r_tc2;

  logic [8:0]     w_sum;
  logic [7:0]     w_total;
  logic [TCW-1:0] w_last_tc;
  logic           w_run;
  logic           w_asg1;
  logic           w_asg2;
  logic [7:0]     w_next2;
  logic [7:0]     w_retired;

  // Assertion takes effect immediately; release is re-timed to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign r_rst_n = r_rst_sync[1];

  assign w_sum     = {1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1);
  assign w_total   = 8'(w_sum >> LOG2);
  assign w_last_tc = (thread_count[LOG2-1:0] == '0) ? TCW'(THREADS_PER_BLOCK)
                                                    : {1'b0, thread_count[LOG2-1:0]};

  assign w_run     = (r_kstate == K_RUN) && start;
  assign w_asg1    = w_run && (r_s1 == S_IDLE) && (r_next < r_total);
  assign w_next2   = w_asg1 ? r_next + 8'd1 : r_next;
  assign w_asg2    = w_run && (r_s2 == S_IDLE) && (w_next2 < r_total);
  assign w_retired = {7'd0, r_s1 == S_RETIRE} + {7'd0, r_s2 == S_RETIRE};

  function automatic logic [TCW-1:0] blk_tc(input logic [7:0] blk);
    return (blk == r_total - 8'd1) ? r_last_tc : TCW'(THREADS_PER_BLOCK);
  endfunction

  function automatic logic [1:0] slot_next(input logic [1:0] st, input logic asg,
                                           input logic wdone);
    logic [1:0] nx;
    nx = st;
    case (st)
      S_IDLE:  if (asg) nx = S_RESET;
      S_RESET: nx = S_RUN;
      S_RUN:   if (wdone) nx = S_RETIRE;
      default: nx = S_IDLE;
    endcase
    return nx;
  endfunction

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_kstate   <= K_IDLE;
      r_total    <= 8'd0;
      r_next     <= 8'd0;
      r_done_cnt <= 8'd0;
      r_last_tc  <= '0;
    end else begin
      case (r_kstate)
        K_IDLE: if (start) begin
          r_kstate   <= K_RUN;
          r_total    <= w_total;
          r_last_tc  <= w_last_tc;
          r_next     <= 8'd0;
          r_done_cnt <= 8'd0;
        end
        K_RUN: if (!start) begin
          r_kstate   <= K_IDLE;
          r_next     <= 8'd0;
          r_done_cnt <= 8'd0;
        end else begin
          if (r_done_cnt == r_total && r_s1 == S_IDLE && r_s2 == S_IDLE)
            r_kstate <= K_DONE;
          r_next     <= r_next + {7'd0, w_asg1} + {7'd0, w_asg2};
          r_done_cnt <= r_done_cnt + w_retired;
        end
        K_DONE: if (!start) r_kstate <= K_IDLE;
        default: r_kstate <= K_IDLE;
      endcase
    end
  end

  // Outside an active, started kernel both slots are parked in S_IDLE.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_s1   <= S_IDLE;
      r_s2   <= S_IDLE;
      r_bid1 <= 8'd0;
      r_bid2 <= 8'd0;
      r_tc1  <= '0;
      r_tc2  <= '0;
    end else if (!w_run) begin
      r_s1 <= S_IDLE;
      r_s2 <= S_IDLE;
    end else begin
      r_s1 <= slot_next(r_s1, w_asg1, warp.done_1);
      r_s2 <= slot_next(r_s2, w_asg2, warp.done_2);
      if (w_asg1) begin
        r_bid1 <= r_next;
        r_tc1  <= blk_tc(r_next);
      end
      if (w_asg2) begin
        r_bid2 <= w_next2;
        r_tc2  <= blk_tc(w_next2);
      end
    end
  end

  assign done                = (r_kstate == K_DONE);
  assign warp.reset_1        = (r_kstate != K_RUN) || (r_s1 == S_RESET);
  assign warp.reset_2        = (r_kstate != K_RUN) || (r_s2 == S_RESET);
  assign warp.start_1        = (r_kstate == K_RUN) && (r_s1 == S_RUN);
  assign warp.start_2        = (r_kstate == K_RUN) && (r_s2 == S_RUN);
  assign warp.block_id_1     = r_bid1;
  assign warp.block_id_2     = r_bid2;
  assign warp.thread_count_1 = r_tc1;
  assign warp.thread_count_2 = r_tc2;
endmodule
`default_nettype wire

// File: tb/tb_warp_dispatch.sv
`default_nettype none
// Bench for warp_dispatch: behavioural two-warp core plus a block-assignment
// scoreboard checked whenever a slot's start rises.
module tb_warp_dispatch;
  localparam int TPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] thread_count = 8'd0;
  logic       done;

  warp_dispatch_if #(.THREADS_PER_BLOCK(TPB)) warp ();

  warp_dispatch #(.THREADS_PER_BLOCK(TPB)) dut (
    .clk(clk), .reset(reset), .start(start),
    .thread_count(thread_count), .done(done), .warp(warp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int slot;
    int blk;
    int tc;
  } exp_t;

  exp_t sb_q[$];
  int n_assert = 0, n_fail = 0;
  int n_started = 0, ncyc = 0, last_wdone_cyc = 0;
  int done_gap = 0, done_rises = 0;
  int lat = 20;
  int cnt1 = 0, cnt2 = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Core model: done_x rises lat cycles after start_x, cleared by reset_x.
  always @(posedge clk) begin
    if (warp.reset_1) begin
      cnt1 <= 0; warp.done_1 <= 1'b0;
    end else if (warp.start_1) begin
      if (cnt1 == lat - 1) warp.done_1 <= 1'b1;
      else cnt1 <= cnt1 + 1;
    end
    if (warp.reset_2) begin
      cnt2 <= 0; warp.done_2 <= 1'b0;
    end else if (warp.start_2) begin
      if (cnt2 == lat - 1) warp.done_2 <= 1'b1;
      else cnt2 <= cnt2 + 1;
    end
  end

  task automatic check_start(input int slot, input int bid, input int tc);
    exp_t e;
    n_started++;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL unexpected_start: slot %0d block %0d tc %0d, expected no start",
               slot, bid, tc);
    end else begin
      e = sb_q.pop_front();
      chk("start_slot", slot, e.slot);
      chk($sformatf("block_id(exp blk %0d)", e.blk), bid, e.blk);
      chk($sformatf("thread_count(blk %0d)", e.blk), tc, e.tc);
    end
  endtask

  logic p_s1 = 1'b0, p_s2 = 1'b0, p_d1 = 1'b0, p_d2 = 1'b0, p_done = 1'b0;
  always @(negedge clk) begin
    ncyc++;
    if (warp.start_1 && !p_s1) check_start(1, int'(warp.block_id_1), int'(warp.thread_count_1));
    if (warp.start_2 && !p_s2) check_start(2, int'(warp.block_id_2), int'(warp.thread_count_2));
    if ((warp.done_1 && !p_d1) || (warp.done_2 && !p_d2)) last_wdone_cyc = ncyc;
    if (done && !p_done) begin
      done_rises++;
      done_gap = ncyc - last_wdone_cyc;
    end
    p_s1 = warp.start_1; p_s2 = warp.start_2;
    p_d1 = warp.done_1;  p_d2 = warp.done_2;
    p_done = done;
  end

  // Equal warp latencies make slot 1 take even blocks, slot 2 odd blocks.
  task automatic push_blocks(input int tc);
    int nb;
    exp_t e;
    nb = (tc + TPB - 1) / TPB;
    for (int b = 0; b < nb; b++) begin
      e.slot = (b % 2 == 0) ? 1 : 2;
      e.blk  = b;
      e.tc   = (b == nb - 1 && tc % TPB != 0) ? tc % TPB : TPB;
      sb_q.push_back(e);
    end
  endtask

  task automatic run_kernel(input int tc);
    int nb, waited;
    nb = (tc + TPB - 1) / TPB;
    push_blocks(tc);
    n_started = 0;
    done_rises = 0;
    thread_count = 8'(tc);
    start = 1'b1;
    waited = 0;
    while (!done && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("tc%0d_done_reached", tc), int'(done), 1);
    @(negedge clk);
    chk($sformatf("tc%0d_done_gap", tc), done_gap, 3);
    chk($sformatf("tc%0d_blocks_started", tc), n_started, nb);
    chk($sformatf("tc%0d_sb_empty", tc), sb_q.size(), 0);
    repeat (3) @(negedge clk);
    chk($sformatf("tc%0d_done_held", tc), int'(done), 1);
    chk($sformatf("tc%0d_done_rises", tc), done_rises, 1);
    chk($sformatf("tc%0d_reset_1_in_done", tc), int'(warp.reset_1), 1);
    start = 1'b0;
    @(negedge clk);
    chk($sformatf("tc%0d_done_clear", tc), int'(done), 0);
    sb_q.delete();
  endtask

  task automatic wait_both_running(input string name);
    int waited;
    waited = 0;
    while (!(warp.start_1 && warp.start_2) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk(name, int'(warp.start_1 && warp.start_2), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_reset_1", int'(warp.reset_1), 1);
    chk("rst_reset_2", int'(warp.reset_2), 1);
    chk("rst_start_1", int'(warp.start_1), 0);
    chk("rst_block_id_2", int'(warp.block_id_2), 0);
    chk("rst_thread_count_1", int'(warp.thread_count_1), 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    run_kernel(10);

    n_started = 0;
    thread_count = 8'd0;
    start = 1'b1;
    @(negedge clk);
    chk("tc0_done_edge_n", int'(done), 0);
    @(negedge clk);
    chk("tc0_done_edge_n1", int'(done), 1);
    repeat (3) @(negedge clk);
    chk("tc0_no_starts", n_started, 0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    run_kernel(8);
    run_kernel(255);

    push_blocks(10);
    n_started = 0;
    thread_count = 8'd10;
    start = 1'b1;
    wait_both_running("abort_both_running");
    start = 1'b0;
    @(negedge clk);
    chk("abort_reset_1", int'(warp.reset_1), 1);
    chk("abort_reset_2", int'(warp.reset_2), 1);
    chk("abort_start_1", int'(warp.start_1), 0);
    chk("abort_start_2", int'(warp.start_2), 0);
    chk("abort_done", int'(done), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    run_kernel(10);

    push_blocks(10);
    thread_count = 8'd10;
    start = 1'b1;
    wait_both_running("rstmid_both_running");
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid_done", int'(done), 0);
    chk("rstmid_reset_1", int'(warp.reset_1), 1);
    chk("rstmid_reset_2", int'(warp.reset_2), 1);
    chk("rstmid_start_1", int'(warp.start_1), 0);
    chk("rstmid_start_2", int'(warp.start_2), 0);
    chk("rstmid_block_id_2", int'(warp.block_id_2), 0);
    chk("rstmid_thread_count_1", int'(warp.thread_count_1), 0);
    sb_q.delete();
    start = 1'b0;
    n_started = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_idle_reset_1", int'(warp.reset_1), 1);
    chk("post_rst_idle_start_1", int'(warp.start_1), 0);
    chk("post_rst_idle_done", int'(done), 0);
    chk("post_rst_no_starts", n_started, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
